mux4_rr_arbiter: RTL
====================

// Module: mux4_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares one output channel among four packet sources.
//   Owns the 2-bit select of a 4-to-1 data mux and routes valid/ready/last.
//   Locks the grant for a whole packet and releases it on the last beat.
//   Sits between four producer ports and a single downstream consumer.
// PARAMETERS
//   WIDTH      8    data bits per source
//   MAX_BEATS  16   max beats per packet before forced release (>=1, <=2**CW)
//   CW         5    beat-counter width
// PORTS
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous, active-high reset
//   in_valid   in   4          per-source beat valid (also the request)
//   in_data    in   4*WIDTH    source i occupies bits [i*WIDTH +: WIDTH]
//   in_last    in   4          per-source last-beat flag
//   in_ready   out  4          per-source ready; only the granted bit can be 1
//   out_valid  out  1          downstream valid
//   out_data   out  WIDTH      in_data slice selected by sel
//   out_last   out  1          in_last[sel]
//   out_ready  in   1          downstream ready
//   sel        out  2          current grant index (mux select)
//   busy       out  1          1 while a grant is held
//   overrun    out  1          one-cycle pulse on forced release
// BEHAVIOUR
//   Reset (async, any time): state=IDLE, ptr=3, sel=0, cnt=0, busy=0,
//     overrun=0, out_valid=0, in_ready=0. A packet in flight is dropped.
//   FSM IDLE:
//     - out_valid=0, in_ready=0.
//     - If any in_valid bit is set, pick the first set bit in the order
//       ptr+1, ptr+2, ptr+3, ptr (mod 4). Register it into sel, set cnt=0,
//       and go to BUSY. Arbitration takes 1 cycle; no data moves in this cycle.
//     - If no in_valid bit is set, stay in IDLE.
//   FSM BUSY:
//     - out_valid=in_valid[sel]; in_ready[sel]=out_ready; other in_ready bits=0.
//     - out_data, out_last: combinational from source sel.
//     - Beat = out_valid & out_ready. On each beat, cnt <= cnt+1.
//     - Beat with out_last=1: ptr<=sel, go to IDLE.
//     - Beat with out_last=0 when cnt==MAX_BEATS-1: ptr<=sel, pulse overrun
//       for 1 cycle, go to IDLE. The beat itself is transferred.
//   The grant does not move while the granted source deasserts valid mid-packet.
//   busy=1 exactly in BUSY. sel holds its value in IDLE.
//   out_valid never depends on out_ready; in_ready[sel] depends on out_ready only.
//   Minimum cost per packet: 1 arbitration cycle + N beat cycles. Back-to-back
//     packets therefore have a 1-cycle gap.
//   After a release, the next arbitration starts from the released index +1,
//     so a source that stays requesting cannot starve another.
// TESTING
//   1 reset, then in_valid=4'b0001, 1-beat packet (last=1), out_ready=1 ->
//     sel=0, beat on cycle 2, busy drops, ptr=0
//   2 in_valid=4'b1111 held, every packet 1 beat ->
//     grant order 0,1,2,3,0; one idle cycle between grants
//   3 src2 sends 3-beat packet while src1 requests; out_ready low on beat 2 ->
//     src1 in_ready stays 0; src2 beat held until out_ready; then src1 granted
//   4 MAX_BEATS=4, src3 streams with last=0 ->
//     4 beats accepted, overrun=1 for one cycle, src0 granted next if requesting
//   5 assert rst mid-packet on src1 beat 2 ->
//     immediately busy=0, in_ready=0, out_valid=0; next grant follows ptr=3, so src0 first
//   6 src0 drops in_valid mid-packet while src1 requests ->
//     sel stays 0, out_valid=0, no switch until src0 completes its last beat

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four packet sources sharing one downstream channel.
// Grant is locked for a whole packet and released on the last beat or after MAX_BEATS beats.
module mux4_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16,
    parameter int CW        = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    input  logic [4*WIDTH-1:0] in_data,
    input  logic [3:0]       in_last,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic [1:0]       sel,
    output logic             busy,
    output logic             overrun
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

    logic [0:0]    state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          overrun_q, overrun_d;

    logic          grant_found;
    logic [1:0]    grant_idx;
    logic [1:0]    cand;
    logic          beat;

    // Search order ptr+1, ptr+2, ptr+3, ptr; first requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!grant_found && in_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign busy      = (state_q == ST_BUSY);
    assign sel       = sel_q;
    assign overrun   = overrun_q;
    assign out_valid = busy & in_valid[sel_q];
    assign out_last  = in_last[sel_q];
    assign out_data  = in_data[sel_q*WIDTH +: WIDTH];
    assign beat      = out_valid & out_ready;

    always_comb begin
        in_ready = '0;
        if (busy) begin
            in_ready[sel_q] = out_ready;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        overrun_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    sel_d   = grant_idx;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            default: begin
                if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                    if (out_last || (cnt_q == LAST_CNT)) begin
                        ptr_d     = sel_q;
                        state_d   = ST_IDLE;
                        overrun_d = ~out_last;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd3;
            sel_q     <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

endmodule
